// File: rtl/systolic_matmul_nxn.sv
// rtl/systolic_matmul_nxn.sv - output-stationary N x N systolic unsigned matrix multiplier
module systolic_matmul_nxn #(
    parameter int N  = 3,
    parameter int DW = 4,
    localparam int LW   = $clog2(N),
    localparam int ACCW = 2*DW + $clog2(N),
    localparam int SUMW = ACCW + 2*$clog2(N),
    localparam int EW   = $clog2(SUMW)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            ld_en,
    input  logic            ld_sel,
    input  logic [LW-1:0]   ld_row,
    input  logic [LW-1:0]   ld_col,
    input  logic [DW-1:0]   ld_data,
    input  logic            start,
    output logic            busy,
    output logic            done,
    input  logic [LW-1:0]   rd_row,
    input  logic [LW-1:0]   rd_col,
    output logic [ACCW-1:0] rd_data,
    output logic [3:0]      norm_mant,
    output logic [EW-1:0]   norm_exp
);
    localparam int KW = $clog2(3*N);
    localparam logic [KW-1:0] KLAST = KW'(3*N-3);
    localparam logic [LW:0]   NL    = (LW+1)'(N);

    typedef enum logic [1:0] {IDLE, FEED, SUM} state_t;
    state_t state;

    logic [KW-1:0]   k;
    logic [DW-1:0]   a_mat  [N][N];
    logic [DW-1:0]   b_mat  [N][N];
    logic [DW-1:0]   a_reg  [N][N];
    logic [DW-1:0]   b_reg  [N][N];
    logic [DW-1:0]   a_in   [N][N];
    logic [DW-1:0]   b_in   [N][N];
    logic [2*DW-1:0] prod   [N][N];
    logic [ACCW-1:0] acc    [N][N];
    logic [DW-1:0]   row_in [N];
    logic [DW-1:0]   col_in [N];
    logic [SUMW-1:0] total;
    logic [3:0]      mant_c;
    logic [EW-1:0]   exp_c;

    // PE(i,j) sees the skewed edge feed in column/row 0, else its neighbour's registered operand
    for (genvar i = 0; i < N; i++) begin : g_row
        for (genvar j = 0; j < N; j++) begin : g_col
            if (j == 0) begin : g_a_edge
                assign a_in[i][j] = row_in[i];
            end else begin : g_a_pass
                assign a_in[i][j] = a_reg[i][j-1];
            end
            if (i == 0) begin : g_b_edge
                assign b_in[i][j] = col_in[j];
            end else begin : g_b_pass
                assign b_in[i][j] = b_reg[i-1][j];
            end
            assign prod[i][j] = {{DW{1'b0}}, a_in[i][j]} * {{DW{1'b0}}, b_in[i][j]};
        end
    end

    always_comb begin
        int d;
        d = 0;
        for (int i = 0; i < N; i++) begin
            row_in[i] = '0;
            col_in[i] = '0;
            d = int'(k) - i;
            if (d >= 0 && d < N) begin
                row_in[i] = a_mat[i][d[LW-1:0]];
                col_in[i] = b_mat[d[LW-1:0]][i];
            end
        end
    end

    always_comb begin
        int lead;
        lead   = 0;
        total  = '0;
        for (int i = 0; i < N; i++)
            for (int j = 0; j < N; j++)
                total = total + {{(SUMW-ACCW){1'b0}}, acc[i][j]};
        for (int b = 0; b < SUMW; b++)
            if (total[b]) lead = b;
        mant_c = total[3:0];
        exp_c  = '0;
        if (total[SUMW-1:3] != '0) begin
            mant_c = 4'(total >> (lead - 3));
            exp_c  = EW'(lead - 3);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            k         <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            rd_data   <= '0;
            norm_mant <= '0;
            norm_exp  <= '0;
            for (int i = 0; i < N; i++)
                for (int j = 0; j < N; j++) begin
                    a_mat[i][j] <= '0;
                    b_mat[i][j] <= '0;
                    a_reg[i][j] <= '0;
                    b_reg[i][j] <= '0;
                    acc[i][j]   <= '0;
                end
        end else begin
            done <= 1'b0;
            if ({1'b0, rd_row} < NL && {1'b0, rd_col} < NL)
                rd_data <= acc[rd_row][rd_col];
            else
                rd_data <= '0;
            case (state)
                IDLE: begin
                    if (ld_en && {1'b0, ld_row} < NL && {1'b0, ld_col} < NL) begin
                        if (ld_sel) b_mat[ld_row][ld_col] <= ld_data;
                        else        a_mat[ld_row][ld_col] <= ld_data;
                    end
                    // done is high only in the first IDLE cycle, so a start there is dropped
                    if (start && !done) begin
                        state <= FEED;
                        k     <= '0;
                        busy  <= 1'b1;
                        for (int i = 0; i < N; i++)
                            for (int j = 0; j < N; j++) begin
                                acc[i][j]   <= '0;
                                a_reg[i][j] <= '0;
                                b_reg[i][j] <= '0;
                            end
                    end
                end
                FEED: begin
                    for (int i = 0; i < N; i++)
                        for (int j = 0; j < N; j++) begin
                            a_reg[i][j] <= a_in[i][j];
                            b_reg[i][j] <= b_in[i][j];
                            acc[i][j]   <= acc[i][j] + {{(ACCW-2*DW){1'b0}}, prod[i][j]};
                        end
                    k <= k + 1'b1;
                    if (k == KLAST) state <= SUM;
                end
                SUM: begin
                    norm_mant <= mant_c;
                    norm_exp  <= exp_c;
                    busy      <= 1'b0;
                    done      <= 1'b1;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_systolic_matmul_nxn.sv
// tb/tb_systolic_matmul_nxn.sv - self-checking bench for systolic_matmul_nxn (N=3/DW=4 and N=4/DW=8)
module tb_systolic_matmul_nxn;
    logic clk = 1'b0;
    always #5 clk = ~clk;
    logic rst;

    logic       ld_en3, ld_sel3, start3, busy3, done3;
    logic [1:0] ld_row3, ld_col3, rd_row3, rd_col3;
    logic [3:0] ld_data3, norm_mant3, norm_exp3;
    logic [9:0] rd_data3;

    logic        ld_en4, ld_sel4, start4, busy4, done4;
    logic [1:0]  ld_row4, ld_col4, rd_row4, rd_col4;
    logic [7:0]  ld_data4;
    logic [3:0]  norm_mant4;
    logic [4:0]  norm_exp4;
    logic [17:0] rd_data4;

    systolic_matmul_nxn #(.N(3), .DW(4)) u3 (
        .clk(clk), .rst(rst), .ld_en(ld_en3), .ld_sel(ld_sel3), .ld_row(ld_row3), .ld_col(ld_col3),
        .ld_data(ld_data3), .start(start3), .busy(busy3), .done(done3), .rd_row(rd_row3),
        .rd_col(rd_col3), .rd_data(rd_data3), .norm_mant(norm_mant3), .norm_exp(norm_exp3)
    );
    systolic_matmul_nxn #(.N(4), .DW(8)) u4 (
        .clk(clk), .rst(rst), .ld_en(ld_en4), .ld_sel(ld_sel4), .ld_row(ld_row4), .ld_col(ld_col4),
        .ld_data(ld_data4), .start(start4), .busy(busy4), .done(done4), .rd_row(rd_row4),
        .rd_col(rd_col4), .rd_data(rd_data4), .norm_mant(norm_mant4), .norm_exp(norm_exp4)
    );

    typedef logic [3:0] m3_t [9];
    typedef logic [7:0] m4_t [16];
    typedef struct {
        m3_t a;
        m3_t b;
        int  mant;
        int  expn;
    } vec_t;

    int     nchk = 0;
    int     nfail = 0;
    longint q3[$];
    longint q4[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        nchk++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic longint pop3();
        if (q3.size() == 0) return -1;
        return q3.pop_front();
    endfunction

    function automatic longint pop4();
        if (q4.size() == 0) return -1;
        return q4.pop_front();
    endfunction

    task automatic load3(input m3_t a, input m3_t b);
        for (int s = 0; s < 2; s++)
            for (int e = 0; e < 9; e++) begin
                @(negedge clk);
                ld_en3   = 1'b1;
                ld_sel3  = (s == 1);
                ld_row3  = 2'(e / 3);
                ld_col3  = 2'(e % 3);
                ld_data3 = (s == 0) ? a[e] : b[e];
            end
        @(negedge clk);
        ld_en3 = 1'b0;
    endtask

    task automatic push3(input m3_t a, input m3_t b, input int mant, input int expn);
        longint c;
        q3.push_back(mant);
        q3.push_back(expn);
        for (int i = 0; i < 3; i++)
            for (int j = 0; j < 3; j++) begin
                c = 0;
                for (int m = 0; m < 3; m++) c += a[i*3+m] * b[m*3+j];
                q3.push_back(c);
            end
    endtask

    task automatic run3(input bit disturb, output int busy_n, output int lat);
        @(negedge clk);
        start3 = 1'b1;
        busy_n = 0;
        lat    = 0;
        for (int c = 1; c <= 60; c++) begin
            @(posedge clk);
            #1;
            start3 = 1'b0;
            ld_en3 = 1'b0;
            if (busy3) busy_n++;
            if (disturb && c == 3) begin
                start3 = 1'b1; ld_en3 = 1'b1; ld_sel3 = 1'b0;
                ld_row3 = 2'd0; ld_col3 = 2'd0; ld_data3 = 4'd7;
            end
            if (done3) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic collect3(input string tag);
        check({tag, "_norm_mant"}, norm_mant3, pop3());
        check({tag, "_norm_exp"}, norm_exp3, pop3());
        for (int e = 0; e < 9; e++) begin
            @(negedge clk);
            rd_row3 = 2'(e / 3);
            rd_col3 = 2'(e % 3);
            @(posedge clk);
            #1;
            check($sformatf("%s_c%0d", tag, e), rd_data3, pop3());
        end
    endtask

    vec_t tbl[3];
    int   bn, lat;
    bit   seen;
    m4_t  a4, b4;
    longint c4;

    initial begin
        rst = 1'b1;
        ld_en3 = 0; ld_sel3 = 0; ld_row3 = 0; ld_col3 = 0; ld_data3 = 0; start3 = 0; rd_row3 = 0; rd_col3 = 0;
        ld_en4 = 0; ld_sel4 = 0; ld_row4 = 0; ld_col4 = 0; ld_data4 = 0; start4 = 0; rd_row4 = 0; rd_col4 = 0;
        for (int e = 0; e < 9; e++) begin
            tbl[0].a[e] = (e / 3 == e % 3) ? 4'd1 : 4'd0;
            tbl[0].b[e] = 4'(e + 1);
            tbl[1].a[e] = 4'd15;
            tbl[1].b[e] = 4'd15;
            tbl[2].a[e] = 4'd0;
            tbl[2].b[e] = 4'd0;
        end
        tbl[0].mant = 4'b1011; tbl[0].expn = 2;
        tbl[1].mant = 4'hB;    tbl[1].expn = 9;
        tbl[2].mant = 0;       tbl[2].expn = 0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy3, 0);
        check("rst_done", done3, 0);
        check("rst_rd_data", rd_data3, 0);
        check("rst_norm_mant", norm_mant3, 0);
        check("rst_norm_exp", norm_exp3, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int t = 0; t < 3; t++) begin
            load3(tbl[t].a, tbl[t].b);
            push3(tbl[t].a, tbl[t].b, tbl[t].mant, tbl[t].expn);
            run3(1'b0, bn, lat);
            check($sformatf("t%0d_busy_len", t), bn, 8);
            check($sformatf("t%0d_done_lat", t), lat, 9);
            collect3($sformatf("t%0d", t));
        end

        // ld_en and start during busy, then start coinciding with done
        load3(tbl[0].a, tbl[0].b);
        push3(tbl[0].a, tbl[0].b, tbl[0].mant, tbl[0].expn);
        run3(1'b1, bn, lat);
        check("dist_busy_len", bn, 8);
        check("dist_done_lat", lat, 9);
        start3 = 1'b1;
        @(posedge clk);
        #1;
        start3 = 1'b0;
        check("start_on_done_ignored", busy3, 0);
        collect3("dist");
        push3(tbl[0].a, tbl[0].b, tbl[0].mant, tbl[0].expn);
        run3(1'b0, bn, lat);
        collect3("ab_unchanged");

        // reset in FEED cycle 3
        load3(tbl[1].a, tbl[1].b);
        @(negedge clk);
        start3 = 1'b1;
        @(posedge clk);
        #1;
        start3 = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        rst = 1'b0;
        check("midrst_busy", busy3, 0);
        check("midrst_done", done3, 0);
        check("midrst_rd_data", rd_data3, 0);
        check("midrst_norm_mant", norm_mant3, 0);
        check("midrst_norm_exp", norm_exp3, 0);
        seen = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (done3) seen = 1'b1;
        end
        check("midrst_no_done", seen, 0);
        load3(tbl[1].a, tbl[1].b);
        push3(tbl[1].a, tbl[1].b, tbl[1].mant, tbl[1].expn);
        run3(1'b0, bn, lat);
        check("rerun_done_lat", lat, 9);
        collect3("rerun");
        @(negedge clk);
        rd_row3 = 2'd3; rd_col3 = 2'd1;
        @(posedge clk);
        #1;
        check("rd_row_oob", rd_data3, 0);
        @(negedge clk);
        rd_row3 = 2'd1; rd_col3 = 2'd3;
        @(posedge clk);
        #1;
        check("rd_col_oob", rd_data3, 0);

        // N=4, DW=8 random runs
        for (int r = 0; r < 20; r++) begin
            for (int e = 0; e < 16; e++) begin
                a4[e] = 8'($urandom_range(0, 255));
                b4[e] = 8'($urandom_range(0, 255));
            end
            if (r == 0) for (int e = 0; e < 16; e++) begin a4[e] = 8'hFF; b4[e] = 8'hFF; end
            for (int s = 0; s < 2; s++)
                for (int e = 0; e < 16; e++) begin
                    @(negedge clk);
                    ld_en4 = 1'b1; ld_sel4 = (s == 1);
                    ld_row4 = 2'(e / 4); ld_col4 = 2'(e % 4);
                    ld_data4 = (s == 0) ? a4[e] : b4[e];
                end
            @(negedge clk);
            ld_en4 = 1'b0;
            for (int i = 0; i < 4; i++)
                for (int j = 0; j < 4; j++) begin
                    c4 = 0;
                    for (int m = 0; m < 4; m++) c4 += a4[i*4+m] * b4[m*4+j];
                    q4.push_back(c4);
                end
            start4 = 1'b1;
            bn = 0; lat = 0;
            for (int c = 1; c <= 60; c++) begin
                @(posedge clk);
                #1;
                start4 = 1'b0;
                if (busy4) bn++;
                if (done4) begin lat = c; break; end
            end
            check($sformatf("n4_r%0d_busy_len", r), bn, 11);
            check($sformatf("n4_r%0d_done_lat", r), lat, 12);
            for (int e = 0; e < 16; e++) begin
                @(negedge clk);
                rd_row4 = 2'(e / 4); rd_col4 = 2'(e % 4);
                @(posedge clk);
                #1;
                check($sformatf("n4_r%0d_c%0d", r, e), rd_data4, pop4());
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
